bram_port_arbiter: RTL and testbench

//  Shares one port of a dual-port block RAM between two requesters (e.g. parser and key loader).

---
 rtl/bram_port_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
//   Shares one port of a dual-port block RAM between two requesters.
//   Grants alternate round-robin. A requester may lock the port for a burst,
//   and an idle lock is dropped after LOCK_TIMEOUT cycles. The RAM port is
//   driven from registers, and read data goes back to the requester that
//   issued the read.
//
// Ports
//   i_clk, i_areset_n            clock, asynchronous active-low reset
//   i_req*/i_we*/i_lock*         per-requester request, write flag, burst lock
//   i_addr*/i_wdata*             per-requester address / write data
//   o_ack*                       combinational grant (transfer = req & ack)
//   o_rvalid*/o_rdata*           read return; o_rvalid* pulses two cycles after the grant
//   o_ram_en/we/addr/wdata       registered RAM port controls
//   i_ram_rdata                  RAM read data (one-cycle latency)
//   o_owner                      {locked, lock owner}
module bram_port_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 64,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                  i_clk,
  input  logic                  i_areset_n,
  input  logic                  i_req0,
  input  logic                  i_we0,
  input  logic                  i_lock0,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [DATA_WIDTH-1:0] i_wdata0,
  input  logic                  i_req1,
  input  logic                  i_we1,
  input  logic                  i_lock1,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [DATA_WIDTH-1:0] i_wdata1,
  output logic                  o_ack0,
  output logic                  o_ack1,
  output logic                  o_rvalid0,
  output logic                  o_rvalid1,
  output logic [DATA_WIDTH-1:0] o_rdata0,
  output logic [DATA_WIDTH-1:0] o_rdata1,
  output logic                  o_ram_en,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata,
  output logic [1:0]            o_owner
);

  // The counter must hold values up to LOCK_TIMEOUT-1. It is kept at least 1 bit wide.
  localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCKED0 = 2'd1,
    LOCKED1 = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic          prio_reg, prio_next;
  logic [TW-1:0] timeout_reg, timeout_next;

  logic [1:0] req, we, lock, ack, xfer;

  logic                  ram_en_reg, ram_we_reg;
  logic [ADDR_WIDTH-1:0] ram_addr_reg;
  logic [DATA_WIDTH-1:0] ram_wdata_reg;
  logic [1:0]            rd_pend_reg;   // read issued to RAM this cycle, per requester
  logic [1:0]            rvalid_reg;    // RAM data for that read is on i_ram_rdata now

  assign req  = {i_req1, i_req0};
  assign we   = {i_we1, i_we0};
  assign lock = {i_lock1, i_lock0};

  // Grant logic. Acks are held low while reset is asserted, so no request
  // can be accepted during reset.
  always_comb begin
    ack = 2'b00;
    case (state_reg)
      IDLE: begin
        ack[0] = req[0] & (~prio_reg | ~req[1]);
        ack[1] = req[1] & ( prio_reg | ~req[0]);
      end
      LOCKED0: ack[0] = req[0];
      LOCKED1: ack[1] = req[1];
      default: ack = 2'b00;
    endcase
    if (!i_areset_n) begin
      ack = 2'b00;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_xfer
      assign xfer[gi] = req[gi] & ack[gi];
    end
  endgenerate

  // State, priority and lock-timeout update.
  always_comb begin
    state_next   = state_reg;
    prio_next    = prio_reg;
    timeout_next = timeout_reg;
    case (state_reg)
      IDLE: begin
        timeout_next = '0;
        if (xfer[0]) begin
          prio_next = 1'b1;
          if (lock[0]) state_next = LOCKED0;
        end else if (xfer[1]) begin
          prio_next = 1'b0;
          if (lock[1]) state_next = LOCKED1;
        end
      end
      LOCKED0: begin
        if (xfer[0]) begin
          timeout_next = '0;
          if (!lock[0]) begin
            state_next = IDLE;
            prio_next  = 1'b1;
          end
        end else if (timeout_reg == TIMEOUT_LAST) begin
          state_next   = IDLE;
          prio_next    = 1'b1;
          timeout_next = '0;
        end else begin
          timeout_next = timeout_reg + 1'b1;
        end
      end
      LOCKED1: begin
        if (xfer[1]) begin
          timeout_next = '0;
          if (!lock[1]) begin
            state_next = IDLE;
            prio_next  = 1'b0;
          end
        end else if (timeout_reg == TIMEOUT_LAST) begin
          state_next   = IDLE;
          prio_next    = 1'b0;
          timeout_next = '0;
        end else begin
          timeout_next = timeout_reg + 1'b1;
        end
      end
      default: begin
        state_next   = IDLE;
        timeout_next = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_reg   <= IDLE;
      prio_reg    <= 1'b0;
      timeout_reg <= '0;
    end else begin
      state_reg   <= state_next;
      prio_reg    <= prio_next;
      timeout_reg <= timeout_next;
    end
  end

  // RAM port pipeline. The address and write data are loaded only on a
  // transfer. The read-return tracking runs two cycles behind the grant to
  // match the one-cycle RAM latency.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      ram_en_reg    <= 1'b0;
      ram_we_reg    <= 1'b0;
      ram_addr_reg  <= '0;
      ram_wdata_reg <= '0;
      rd_pend_reg   <= 2'b00;
      rvalid_reg    <= 2'b00;
    end else begin
      ram_en_reg  <= |xfer;
      ram_we_reg  <= (xfer[0] & we[0]) | (xfer[1] & we[1]);
      rd_pend_reg <= xfer & ~we;
      rvalid_reg  <= rd_pend_reg;
      if (xfer[1]) begin
        ram_addr_reg  <= i_addr1;
        ram_wdata_reg <= i_wdata1;
      end else if (xfer[0]) begin
        ram_addr_reg  <= i_addr0;
        ram_wdata_reg <= i_wdata0;
      end
    end
  end

  assign o_ack0      = ack[0];
  assign o_ack1      = ack[1];
  assign o_ram_en    = ram_en_reg;
  assign o_ram_we    = ram_we_reg;
  assign o_ram_addr  = ram_addr_reg;
  assign o_ram_wdata = ram_wdata_reg;
  assign o_rvalid0   = rvalid_reg[0];
  assign o_rvalid1   = rvalid_reg[1];
  assign o_rdata0    = i_ram_rdata;
  assign o_rdata1    = i_ram_rdata;
  assign o_owner     = {state_reg != IDLE, state_reg == LOCKED1};

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter
//   Directed bench for bram_port_arbiter. The bench contains a small block-RAM
//   model with registered read. Each RAM word is initialised to 0xA0 + address.
//   Inputs are driven 1 time unit after the rising edge, and outputs are sampled
//   1 time unit later.
module tb_bram_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 64;

  logic          i_clk = 1'b0;
  logic          i_areset_n;
  logic          i_req0, i_we0, i_lock0, i_req1, i_we1, i_lock1;
  logic [AW-1:0] i_addr0, i_addr1;
  logic [DW-1:0] i_wdata0, i_wdata1;
  logic          o_ack0, o_ack1, o_rvalid0, o_rvalid1;
  logic [DW-1:0] o_rdata0, o_rdata1;
  logic          o_ram_en, o_ram_we;
  logic [AW-1:0] o_ram_addr;
  logic [DW-1:0] o_ram_wdata;
  logic [DW-1:0] i_ram_rdata;
  logic [1:0]    o_owner;

  always #5 i_clk = ~i_clk;

  bram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_TIMEOUT(16)) dut (
    .i_clk(i_clk), .i_areset_n(i_areset_n),
    .i_req0(i_req0), .i_we0(i_we0), .i_lock0(i_lock0), .i_addr0(i_addr0), .i_wdata0(i_wdata0),
    .i_req1(i_req1), .i_we1(i_we1), .i_lock1(i_lock1), .i_addr1(i_addr1), .i_wdata1(i_wdata1),
    .o_ack0(o_ack0), .o_ack1(o_ack1),
    .o_rvalid0(o_rvalid0), .o_rvalid1(o_rvalid1),
    .o_rdata0(o_rdata0), .o_rdata1(o_rdata1),
    .o_ram_en(o_ram_en), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr),
    .o_ram_wdata(o_ram_wdata), .i_ram_rdata(i_ram_rdata), .o_owner(o_owner)
  );

  // RAM model: read-first, one-cycle registered read.
  logic [DW-1:0] mem [256];
  always @(posedge i_clk) begin
    if (o_ram_en) begin
      if (o_ram_we) mem[o_ram_addr] <= o_ram_wdata;
      i_ram_rdata <= mem[o_ram_addr];
    end
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive0(input logic req, input logic we, input logic lock,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    i_req0 = req; i_we0 = we; i_lock0 = lock; i_addr0 = a; i_wdata0 = d;
  endtask

  task automatic drive1(input logic req, input logic we, input logic lock,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    i_req1 = req; i_we1 = we; i_lock1 = lock; i_addr1 = a; i_wdata1 = d;
  endtask

  // Expected per-cycle pattern for the two-requester read stream (bit i = cycle i).
  logic [5:0] e_ack0 = 6'b000101;
  logic [5:0] e_ack1 = 6'b001010;
  logic [5:0] e_rv0  = 6'b010100;
  logic [5:0] e_rv1  = 6'b101000;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 64'hA0 + 64'(i);
    i_ram_rdata = '0;
    i_areset_n  = 1'b0;
    drive0(1'b1, 1'b0, 1'b0, 8'h05, '0);
    drive1(1'b1, 1'b0, 1'b0, 8'h20, '0);

    // Reset: outputs low and acks held off even with requests present.
    #2;
    check("rst ack0", o_ack0, 0);
    check("rst ack1", o_ack1, 0);
    check("rst ram_en", o_ram_en, 0);
    check("rst owner", o_owner, 0);
    cyc(); cyc();
    check("rst ram_en held", o_ram_en, 0);
    check("rst rvalid0", o_rvalid0, 0);

    cyc();
    i_areset_n = 1'b1;
    i_req0 = 1'b0; i_req1 = 1'b0;
    settle();
    check("idle ack0", o_ack0, 0);
    check("idle ack1", o_ack1, 0);
    check("idle ram_en", o_ram_en, 0);

    // Single read from req0 of address 0x05.
    cyc(); drive0(1'b1, 1'b0, 1'b0, 8'h05, '0); settle();
    check("rd ack0", o_ack0, 1);
    check("rd ack1", o_ack1, 0);
    cyc(); i_req0 = 1'b0; settle();
    check("rd ram_en", o_ram_en, 1);
    check("rd ram_we", o_ram_we, 0);
    check("rd ram_addr", o_ram_addr, 8'h05);
    check("rd rvalid0 early", o_rvalid0, 0);
    cyc(); settle();
    check("rd rvalid0", o_rvalid0, 1);
    check("rd rdata0", o_rdata0, 64'hA5);
    check("rd rvalid1", o_rvalid1, 0);
    cyc(); settle();
    check("rd rvalid0 end", o_rvalid0, 0);
    check("rd ram_en end", o_ram_en, 0);

    // req1 write passes priority back to requester 0.
    cyc(); drive1(1'b1, 1'b1, 1'b0, 8'h30, 64'h1234); settle();
    check("wr1 ack1", o_ack1, 1);

    // Both requesters stream reads: grants alternate with no bubbles.
    cyc();
    drive0(1'b1, 1'b0, 1'b0, 8'h10, '0);
    drive1(1'b1, 1'b0, 1'b0, 8'h20, '0);
    settle();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        cyc();
        if (i == 4) begin i_req0 = 1'b0; i_req1 = 1'b0; end
        settle();
      end
      check($sformatf("rr ack0[%0d]", i), o_ack0, e_ack0[i]);
      check($sformatf("rr ack1[%0d]", i), o_ack1, e_ack1[i]);
      check($sformatf("rr rvalid0[%0d]", i), o_rvalid0, e_rv0[i]);
      check($sformatf("rr rvalid1[%0d]", i), o_rvalid1, e_rv1[i]);
      if (e_rv0[i]) check($sformatf("rr rdata0[%0d]", i), o_rdata0, 64'hB0);
      if (e_rv1[i]) check($sformatf("rr rdata1[%0d]", i), o_rdata1, 64'hC0);
    end

    // Locked burst of 4 writes by req0 while req1 waits.
    cyc();
    drive1(1'b1, 1'b0, 1'b0, 8'h20, '0);
    drive0(1'b1, 1'b1, 1'b1, 8'h50, 64'h100);
    settle();
    check("burst0 ack0", o_ack0, 1);
    check("burst0 ack1", o_ack1, 0);
    check("burst0 owner", o_owner, 2'b00);
    for (int k = 1; k < 4; k++) begin
      cyc();
      drive0(1'b1, 1'b1, (k < 3), 8'(8'h50 + k), 64'h100 + 64'(k));
      settle();
      check($sformatf("burst%0d ack0", k), o_ack0, 1);
      check($sformatf("burst%0d ack1", k), o_ack1, 0);
      check($sformatf("burst%0d owner", k), o_owner, 2'b10);
      check($sformatf("burst%0d ram_we", k), o_ram_we, 1);
      check($sformatf("burst%0d ram_addr", k), o_ram_addr, 8'(8'h50 + k - 1));
      check($sformatf("burst%0d rvalid0", k), o_rvalid0, 0);
    end
    cyc(); i_req0 = 1'b0; settle();
    check("burst end ack1", o_ack1, 1);
    check("burst end owner", o_owner, 2'b00);
    check("burst end ram_addr", o_ram_addr, 8'h53);
    check("burst end ram_wdata", o_ram_wdata, 64'h103);

    // Lock timeout: req0 locks with a read, then goes quiet while req1 waits.
    cyc(); drive0(1'b1, 1'b0, 1'b1, 8'h10, '0); settle();
    check("lk ack0", o_ack0, 1);
    check("lk ack1", o_ack1, 0);
    for (int j = 1; j <= 16; j++) begin
      cyc();
      if (j == 1) i_req0 = 1'b0;
      settle();
      check($sformatf("lk wait ack1[%0d]", j), o_ack1, 0);
      if (j == 2) begin
        check("lk rvalid0", o_rvalid0, 1);
        check("lk rdata0", o_rdata0, 64'hB0);
      end
      if (j == 16) check("lk owner", o_owner, 2'b10);
    end
    cyc(); settle();
    check("lk release ack1", o_ack1, 1);
    check("lk release owner", o_owner, 2'b00);
    cyc(); i_req1 = 1'b0; settle();

    // Read one cycle after a write to the same address sees the new data.
    cyc(); drive0(1'b1, 1'b1, 1'b0, 8'h40, 64'hDEAD); settle();
    check("raw wr ack0", o_ack0, 1);
    cyc(); drive0(1'b1, 1'b0, 1'b0, 8'h40, '0); settle();
    check("raw rd ack0", o_ack0, 1);
    check("raw wr ram_we", o_ram_we, 1);
    cyc(); i_req0 = 1'b0; settle();
    check("raw rd ram_we", o_ram_we, 0);
    check("raw rd ram_addr", o_ram_addr, 8'h40);
    cyc(); settle();
    check("raw rvalid0", o_rvalid0, 1);
    check("raw rdata0", o_rdata0, 64'hDEAD);

    // Reset one cycle after a read is accepted discards that read.
    cyc(); drive0(1'b1, 1'b0, 1'b0, 8'h05, '0); settle();
    check("rr2 ack0", o_ack0, 1);
    cyc();
    i_areset_n = 1'b0;
    drive1(1'b1, 1'b0, 1'b0, 8'h20, '0);
    settle();
    check("rr2 rst ram_en", o_ram_en, 0);
    check("rr2 rst ack0", o_ack0, 0);
    check("rr2 rst ack1", o_ack1, 0);
    cyc(); settle();
    check("rr2 rst rvalid0", o_rvalid0, 0);
    cyc(); i_areset_n = 1'b1; settle();
    check("post rst ack0", o_ack0, 1);
    check("post rst ack1", o_ack1, 0);
    check("post rst rvalid0", o_rvalid0, 0);
    cyc(); i_req0 = 1'b0; i_req1 = 1'b0; settle();
    check("post rst rvalid0 n+1", o_rvalid0, 0);
    check("post rst ram_en", o_ram_en, 1);
    cyc(); settle();
    check("post rst rvalid0 n+2", o_rvalid0, 1);
    check("post rst rdata0", o_rdata0, 64'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
